// File: rtl/table_mem_pkg.sv
// Shared constants and helpers for the match-stage lookup-table memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   TRUE/FALSE       : single-bit logic constants
//   ADDR_BUS/DATA_BUS/BYTE_BUS : bus widths of the matcher memory interface
//   MEM_MAX_WIDTH    : largest legal access width in bytes (DATA_BUS/8)
//   TABLE_MEM_BYTES  : flow-table capacity; the matcher sizes entries against it
package table_mem_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int ADDR_BUS  = 32;
   localparam int DATA_BUS  = 64;
   localparam int BYTE_BUS  = 8;
   localparam int WIDTH_BUS = 4;

   localparam int MEM_MAX_WIDTH   = DATA_BUS / 8;
   localparam int TABLE_MEM_BYTES = 4096;

   // A width of zero or anything beyond the data bus is answered without
   // touching the array.
   function automatic logic width_legal(input logic [WIDTH_BUS-1:0] width,
                                        input int max_width);
      return (width != '0) && (int'(width) <= max_width);
   endfunction

endpackage

// File: rtl/table_mem_if.sv
// Matcher-to-table memory request bus: level request held until a ready pulse.
// Latency: set by the slave (width+1 cycles after accept for legal widths).
// Backpressure: the master holds mem_ce_i and its qualifiers until mem_ready_o.
//   master : initiator (matcher / testbench) drives request fields
//   slave  : table_mem returns read data and the completion pulse
interface table_mem_if;
   import table_mem_pkg::*;

   logic                 mem_ce_i;
   logic                 mem_we_i;
   logic [ADDR_BUS-1:0]  mem_addr_i;
   logic [WIDTH_BUS-1:0] mem_width_i;
   logic [DATA_BUS-1:0]  mem_data_i;
   logic [DATA_BUS-1:0]  mem_data_o;
   logic                 mem_ready_o;

   modport master (
      output mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
      input  mem_data_o, mem_ready_o
   );

   modport slave (
      input  mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
      output mem_data_o, mem_ready_o
   );

endinterface

// File: rtl/table_mem_byte_ram.sv
// Single-port byte array backing the flow table; contents are never reset.
// Latency: combinational read, write lands on the next clk edge.
// Backpressure: none; one access per cycle, arbitration is the parent's job.
//   clk   : clock
//   we    : byte write enable
//   addr  : byte address (already wrapped to the array size)
//   wdata : byte to write
//   rdata : byte currently stored at addr
module byte_ram #(
   parameter int MEM_BYTES = 4096,
   parameter int AW        = $clog2(MEM_BYTES)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [MEM_BYTES];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/table_mem.sv
// Byte-serial lookup-table memory for the matcher, plus a control-plane byte loader.
// Latency: legal request ready in cycle width+1 after accept; illegal width in cycle 1.
// Backpressure: one request at a time (width+2 cycles each); cfg writes only land in IDLE.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : matcher request interface (slave side)
//   cfg_we_i   : control-plane byte write strobe, ignored while cfg_busy_o
//   cfg_addr_i : control-plane byte address
//   cfg_data_i : control-plane byte
//   cfg_busy_o : high whenever a request is in flight
module table_mem
   import table_mem_pkg::*;
#(
   parameter int MEM_BYTES = TABLE_MEM_BYTES,
   parameter int MAX_WIDTH = MEM_MAX_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   table_mem_if.slave          bus,
   input  logic                cfg_we_i,
   input  logic [ADDR_BUS-1:0] cfg_addr_i,
   input  logic [BYTE_BUS-1:0] cfg_data_i,
   output logic                cfg_busy_o
);

   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DONE
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [AW-1:0]        addr_q;
   logic                 we_q;
   logic [WIDTH_BUS-1:0] width_q;
   logic [WIDTH_BUS-1:0] idx_q;
   logic [DATA_BUS-1:0]  wdata_q;
   logic [DATA_BUS-1:0]  rdata_q;

   logic                 accept;
   logic                 req_legal;
   logic                 last_byte;
   logic [5:0]           byte_sel;

   logic                 ram_we;
   logic [AW-1:0]        ram_addr;
   logic [7:0]           ram_wdata;
   logic [7:0]           ram_rdata;

   // Only the low AW address bits select a byte; the rest wrap away.
   logic                 unused_addr_hi;
   assign unused_addr_hi = ^{bus.mem_addr_i[ADDR_BUS-1:AW], cfg_addr_i[ADDR_BUS-1:AW]};

   // A cfg write in the same IDLE cycle wins; the request simply waits a cycle.
   assign accept    = (state_q == IDLE) && !cfg_we_i && bus.mem_ce_i;
   assign req_legal = width_legal(bus.mem_width_i, MAX_WIDTH);
   assign last_byte = (idx_q == width_q - 4'd1);
   assign byte_sel  = {idx_q[2:0], 3'b000};

   assign bus.mem_data_o  = rdata_q;
   assign bus.mem_ready_o = (state_q == DONE);
   assign cfg_busy_o      = (state_q != IDLE);

   // Next state and RAM port mux: cfg owns the port in IDLE, the engine in XFER.
   always_comb begin
      state_d   = state_q;
      ram_we    = FALSE;
      ram_addr  = '0;
      ram_wdata = '0;

      case (state_q)
         IDLE: begin
            if (cfg_we_i) begin
               ram_we    = TRUE;
               ram_addr  = cfg_addr_i[AW-1:0];
               ram_wdata = cfg_data_i;
            end else if (bus.mem_ce_i) begin
               state_d = req_legal ? XFER : DONE;
            end
         end
         XFER: begin
            // Natural AW-bit overflow gives the modulo-MEM_BYTES wrap.
            ram_we    = we_q;
            ram_addr  = addr_q + AW'(idx_q);
            ram_wdata = wdata_q[byte_sel +: 8];
            if (last_byte) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= FALSE;
         width_q <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q  <= bus.mem_addr_i[AW-1:0];
                  we_q    <= bus.mem_we_i;
                  width_q <= bus.mem_width_i;
                  wdata_q <= bus.mem_data_i;
                  idx_q   <= '0;
                  // Reads start from zero so bytes above width read back as 0,
                  // and an illegal-width read returns 0.
                  if (!bus.mem_we_i) begin
                     rdata_q <= '0;
                  end
               end
            end
            XFER: begin
               if (!we_q) begin
                  rdata_q[byte_sel +: 8] <= ram_rdata;
               end
               idx_q <= idx_q + 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

   byte_ram #(
      .MEM_BYTES (MEM_BYTES),
      .AW        (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_table_mem.sv
module tb_table_mem;
   import table_mem_pkg::*;

   typedef struct {
      int                  lat;
      logic [DATA_BUS-1:0] data;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                cfg_we = 1'b0;
   logic [ADDR_BUS-1:0] cfg_addr = '0;
   logic [BYTE_BUS-1:0] cfg_data = '0;
   logic                cfg_busy;

   table_mem_if bus();

   table_mem #(
      .MEM_BYTES (TABLE_MEM_BYTES),
      .MAX_WIDTH (MEM_MAX_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .cfg_we_i   (cfg_we),
      .cfg_addr_i (cfg_addr),
      .cfg_data_i (cfg_data),
      .cfg_busy_o (cfg_busy)
   );

   always #5 clk = ~clk;

   int                  n_checks = 0;
   int                  n_fail   = 0;
   exp_t                sb[$];
   logic [7:0]          shadow [TABLE_MEM_BYTES];
   logic [DATA_BUS-1:0] last_rd = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic cfg_wr(input int a, input logic [7:0] d);
      cfg_we   = 1'b1;
      cfg_addr = ADDR_BUS'(a);
      cfg_data = d;
      shadow[a % TABLE_MEM_BYTES] = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Drives a request and pushes its expected latency/data. extra adds cycles
   // the request spends waiting before its accept cycle.
   task automatic issue(input bit we, input int a, input int w,
                        input logic [63:0] d, input int extra);
      exp_t e;
      bit   legal;
      legal = (w >= 1) && (w <= MEM_MAX_WIDTH);
      bus.mem_ce_i    = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_addr_i  = ADDR_BUS'(a);
      bus.mem_width_i = 4'(w);
      bus.mem_data_i  = d;
      e.lat = (legal ? w + 1 : 1) + extra;
      if (we) begin
         if (legal) begin
            for (int i = 0; i < w; i++) shadow[(a + i) % TABLE_MEM_BYTES] = d[8*i +: 8];
         end
         e.data = last_rd;
      end else begin
         e.data = '0;
         if (legal) begin
            for (int i = 0; i < w; i++) e.data[8*i +: 8] = shadow[(a + i) % TABLE_MEM_BYTES];
         end
         last_rd = e.data;
      end
      sb.push_back(e);
   endtask

   task automatic wait_ready(input bit keep_ce, input int n0);
      int   n;
      bit   got;
      exp_t e;
      n   = n0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         got = bus.mem_ready_o;
      end
      check("ready_seen", 64'(got), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (got) begin
            check("latency", 64'(n), 64'(e.lat));
            check("rdata", bus.mem_data_o, e.data);
         end
      end
      if (!keep_ce) begin
         bus.mem_ce_i = 1'b0;
         @(negedge clk);
         check("ready_pulse", 64'(bus.mem_ready_o), 64'd0);
         check("busy_idle", 64'(cfg_busy), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.mem_ce_i    = 1'b0;
      bus.mem_we_i    = 1'b0;
      bus.mem_addr_i  = '0;
      bus.mem_width_i = '0;
      bus.mem_data_i  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(bus.mem_ready_o), 64'd0);
      check("rst_data", bus.mem_data_o, 64'd0);
      check("rst_busy", 64'(cfg_busy), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_ready", 64'(bus.mem_ready_o), 64'd0);
      check("idle_busy", 64'(cfg_busy), 64'd0);

      // cfg load then 4-byte read
      cfg_wr(32'h100, 8'h11);
      cfg_wr(32'h101, 8'h22);
      cfg_wr(32'h102, 8'h33);
      cfg_wr(32'h103, 8'h44);
      issue(1'b0, 32'h100, 4, '0, 0);
      wait_ready(1'b0, 0);
      check("rd4_const", last_rd, 64'h0000_0000_4433_2211);

      // Partial write, then back-to-back read; then full-width read
      for (int i = 0; i < 8; i++) cfg_wr(32'h200 + i, 8'(8'h90 + i));
      issue(1'b1, 32'h200, 2, 64'hFFFF_FFFF_FFFF_BEEF, 0);
      wait_ready(1'b1, 0);
      issue(1'b0, 32'h200, 2, '0, 1);
      wait_ready(1'b0, 0);
      issue(1'b0, 32'h200, 8, '0, 0);
      wait_ready(1'b0, 0);
      check("rd8_const", last_rd, 64'h9796_9594_9392_BEEF);

      // Illegal widths
      issue(1'b0, 32'h100, 0, '0, 0);
      wait_ready(1'b0, 0);
      issue(1'b1, 32'h100, 9, 64'hDEAD_DEAD_DEAD_DEAD, 0);
      wait_ready(1'b0, 0);
      issue(1'b0, 32'h100, 9, '0, 0);
      wait_ready(1'b0, 0);
      issue(1'b0, 32'h100, 4, '0, 0);
      wait_ready(1'b0, 0);

      // Address wrap
      issue(1'b1, TABLE_MEM_BYTES - 2, 4, 64'hA1B2C3D4, 0);
      wait_ready(1'b0, 0);
      issue(1'b0, TABLE_MEM_BYTES - 2, 2, '0, 0);
      wait_ready(1'b0, 0);
      issue(1'b0, 0, 2, '0, 0);
      wait_ready(1'b0, 0);
      check("wrap_low", last_rd, 64'h0000_0000_0000_A1B2);

      // cfg write and request in the same cycle: request accepted one cycle later
      cfg_we   = 1'b1;
      cfg_addr = 32'h400;
      cfg_data = 8'h5A;
      shadow[32'h400] = 8'h5A;
      issue(1'b0, 32'h400, 1, '0, 1);
      @(negedge clk);
      cfg_we = 1'b0;
      wait_ready(1'b0, 1);

      // Reset during a width-8 write
      for (int i = 0; i < 8; i++) cfg_wr(32'h300 + i, 8'(8'h60 + i));
      bus.mem_ce_i    = 1'b1;
      bus.mem_we_i    = 1'b1;
      bus.mem_addr_i  = 32'h300;
      bus.mem_width_i = 4'd8;
      bus.mem_data_i  = 64'h1122_3344_5566_7788;
      @(negedge clk);
      check("xfer_busy", 64'(cfg_busy), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_ready", 64'(bus.mem_ready_o), 64'd0);
      check("abort_busy", 64'(cfg_busy), 64'd0);
      check("abort_data", bus.mem_data_o, 64'd0);
      shadow[32'h300] = 8'h88;
      shadow[32'h301] = 8'h77;
      last_rd = '0;
      bus.mem_ce_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_ready", 64'(bus.mem_ready_o), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      issue(1'b0, 32'h300, 8, '0, 0);
      wait_ready(1'b0, 0);
      check("abort_bytes", last_rd, 64'h6766_6564_6362_7788);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
